sr_excitation_tx: RTL and testbench

- Transmitter side of the S/R flip-flop interface: accepts a parallel word over a valid/ready handshake and serialises it one bit per clock as S/R excitation pairs.
- A downstream SR flip-flop clocked by the same clk reproduces the word bit-by-bit on its Q.
- Keeps an internal model of the downstream Q and emits the minimal excitation per bit (set, reset or hold).
- Never drives the illegal S=R=1 combination.

---
 rtl/sr_excitation_tx_pkg.sv | 34 +++
 rtl/sr_excitation_tx_if.sv | 28 ++
 rtl/sr_excitation_tx_sr_model.sv | 40 ++++
 rtl/sr_excitation_tx.sv | 146 ++++++++++++++
 tb/tb_sr_excitation_tx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_excitation_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_tx_pkg
// Description : Shared types and helpers for the S/R excitation transmitter:
//               FSM state encoding and the SR flip-flop excitation function.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_tx_pkg;

    // Width of the default configuration and its bit-index width.
    localparam int DEFAULT_WIDTH = 8;
    localparam int IDX_W         = $clog2(DEFAULT_WIDTH);

    // Transmitter frame phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        SHIFT  = 2'd2,
        RETURN = 2'd3
    } state_t;

    // Minimal SR excitation moving Q from q to target t, returned as {S,R}.
    // Never produces {1,1}.
    function automatic logic [1:0] exc(input logic t, input logic q);
        logic [1:0] sr;
        sr = 2'b00;
        if (t != q) begin
            sr = t ? 2'b10 : 2'b01;
        end
        return sr;
    endfunction

endpackage : sr_tx_pkg
`default_nettype wire

// File: rtl/sr_excitation_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_excitation_tx_if
// Description : valid/ready word-input handshake of the S/R transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_excitation_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    // Word producer side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Transmitter side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface : sr_excitation_tx_if
`default_nettype wire

// File: rtl/sr_excitation_tx_sr_model.sv
`default_nettype none
// ============================================================================
// Module      : sr_model
// Description : Exact registered model of an SR flip-flop. Set wins over hold,
//               reset clears; resets asynchronously to IDLE_Q. Also exposes the
//               value Q will take at the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_model #(
    parameter bit IDLE_Q = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic s,
    input  wire logic r,
    output logic      q,
    output logic      q_next
);

    // Next-state of the flip-flop from the excitation currently applied.
    always_comb begin
        q_next = q;
        if (s) begin
            q_next = 1'b1;
        end else if (r) begin
            q_next = 1'b0;
        end
    end

    // Flip-flop storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IDLE_Q;
        end else begin
            q <= q_next;
        end
    end

endmodule : sr_model
`default_nettype wire

// File: rtl/sr_excitation_tx.sv
`default_nettype none
// ============================================================================
// Module      : sr_excitation_tx
// Description : Serialises a parallel word into per-clock S/R excitation pairs
//               for a downstream SR flip-flop. Each frame forces the receiver
//               to IDLE_Q, sends WIDTH bits with minimal excitation, then
//               returns the receiver to IDLE_Q.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_excitation_tx
    import sr_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_Q    = 1'b0
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    sr_excitation_tx_if.slave             in_if,
    output logic                          S,
    output logic                          R,
    output logic                          q_model,
    output logic                          busy,
    output logic [$clog2(WIDTH)-1:0]      bit_idx,
    output logic                          frame_done
);

    localparam int                 c_IDX_W    = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);
    // Excitation that drives the receiver to IDLE_Q unconditionally.
    localparam logic [1:0]         c_FORCE_SR = IDLE_Q ? 2'b10 : 2'b01;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   w_shreg_adv;
    logic [1:0]         r_sr;
    logic [1:0]         w_sr_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_cur_bit;
    logic               w_q_next;

    // Receiver model, fed by the registered excitation actually on the wire.
    sr_model #(
        .IDLE_Q (IDLE_Q)
    ) u_sr_model (
        .clk    (clk),
        .rst_n  (rst_n),
        .s      (r_sr[1]),
        .r      (r_sr[0]),
        .q      (q_model),
        .q_next (w_q_next)
    );

    // Bit to transmit next and the shift register after consuming it.
    always_comb begin
        if (MSB_FIRST) begin
            w_cur_bit   = r_shreg[WIDTH-1];
            w_shreg_adv = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
            w_cur_bit   = r_shreg[0];
            w_shreg_adv = {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    // Frame sequencing: next state, next excitation and bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_sr_nxt    = 2'b00;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                if (in_if.in_valid) begin
                    w_shreg_nxt = in_if.in_data;
                    w_sr_nxt    = c_FORCE_SR;
                    w_state_nxt = INIT;
                end
            end

            INIT: begin
                // Receiver is known to land on IDLE_Q at this edge, so the
                // first bit is excited relative to IDLE_Q directly.
                w_sr_nxt    = exc(w_cur_bit, IDLE_Q);
                w_shreg_nxt = w_shreg_adv;
                w_idx_nxt   = '0;
                w_state_nxt = SHIFT;
            end

            SHIFT: begin
                if (r_idx == c_LAST_IDX) begin
                    // Last data bit is on the wire; steer back to idle level.
                    w_sr_nxt    = exc(IDLE_Q, w_q_next);
                    w_state_nxt = RETURN;
                end else begin
                    w_sr_nxt    = exc(w_cur_bit, w_q_next);
                    w_shreg_nxt = w_shreg_adv;
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end

            RETURN: begin
                w_done_nxt  = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_sr    <= 2'b00;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_sr    <= w_sr_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign S              = r_sr[1];
    assign R              = r_sr[0];
    assign bit_idx        = r_idx;
    assign frame_done     = r_done;
    assign busy           = (r_state != IDLE);
    assign in_if.in_ready = (r_state == IDLE);

endmodule : sr_excitation_tx
`default_nettype wire

// File: tb/tb_sr_excitation_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sr_excitation_tx
// Description : Bench for sr_excitation_tx. Two instances (MSB-first/idle-0
//               and LSB-first/idle-1) share one stimulus stream; each is
//               compared cycle by cycle against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_excitation_tx;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

    typedef struct {
        logic s;
        logic r;
        logic busy;
        logic rdy;
        logic done;
        logic q;
        int   idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         drv_v;
    logic [W-1:0] drv_d;

    logic          s0, r0, qm0, b0, d0, rxq0, rxn0;
    logic          s1, r1, qm1, b1, d1, rxq1, rxn1;
    logic [IW-1:0] i0, i1;

    exp_t exp0[$];
    exp_t exp1[$];
    exp_t last0;
    logic model_rdy;
    int   total  = 0;
    int   bad    = 0;
    int   frames = 0;

    always #5 clk = ~clk;

    sr_excitation_tx_if #(.WIDTH(W)) if0 ();
    sr_excitation_tx_if #(.WIDTH(W)) if1 ();

    assign if0.in_valid = drv_v;
    assign if0.in_data  = drv_d;
    assign if1.in_valid = drv_v;
    assign if1.in_data  = drv_d;

    sr_excitation_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_Q(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_if(if0), .S(s0), .R(r0), .q_model(qm0),
        .busy(b0), .bit_idx(i0), .frame_done(d0)
    );

    sr_excitation_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_Q(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_if(if1), .S(s1), .R(r1), .q_model(qm1),
        .busy(b1), .bit_idx(i1), .frame_done(d1)
    );

    // Downstream receivers clocked by the same clk.
    sr_model #(.IDLE_Q(1'b0)) rx0 (
        .clk(clk), .rst_n(rst_n), .s(s0), .r(r0), .q(rxq0), .q_next(rxn0)
    );
    sr_model #(.IDLE_Q(1'b1)) rx1 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(rxq1), .q_next(rxn1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t idle_exp(input int which);
        exp_t e;
        e.s = 1'b0; e.r = 1'b0; e.busy = 1'b0; e.rdy = 1'b1; e.done = 1'b0;
        e.q = (which == 1); e.idx = 0;
        return e;
    endfunction

    // Frame-level reference: a list of receiver targets (idle level, the data
    // bits in transmit order, idle level), each excited relative to the
    // previous target, followed by the completion cycle.
    task automatic push_frame(input int which, input logic [W-1:0] w);
        logic msb, iq, qp;
        logic tgt [W+2];
        exp_t e;
        msb = (which == 0);
        iq  = (which == 1);
        tgt[0] = iq;
        for (int i = 0; i < W; i++) tgt[i+1] = msb ? w[W-1-i] : w[i];
        tgt[W+1] = iq;
        for (int j = 0; j <= W + 1; j++) begin
            qp = (j == 0) ? iq : tgt[j-1];
            e.q = qp;
            if (j == 0) begin
                e.s = iq; e.r = !iq;
            end else begin
                e.s = tgt[j] & !qp;
                e.r = !tgt[j] & qp;
            end
            e.busy = 1'b1; e.rdy = 1'b0; e.done = 1'b0;
            e.idx  = (j == 0) ? 0 : ((j <= W) ? j - 1 : W - 1);
            if (which == 0) exp0.push_back(e); else exp1.push_back(e);
        end
        e.s = 1'b0; e.r = 1'b0; e.busy = 1'b0; e.rdy = 1'b1; e.done = 1'b1;
        e.q = iq; e.idx = 0;
        if (which == 0) exp0.push_back(e); else exp1.push_back(e);
    endtask

    task automatic compare(input int which, input exp_t e);
        logic s, r, b, rd, d, q, rq;
        logic [IW-1:0] ix;
        string p;
        p  = (which == 0) ? "d0" : "d1";
        s  = (which == 0) ? s0 : s1;
        r  = (which == 0) ? r0 : r1;
        b  = (which == 0) ? b0 : b1;
        rd = (which == 0) ? if0.in_ready : if1.in_ready;
        d  = (which == 0) ? d0 : d1;
        q  = (which == 0) ? qm0 : qm1;
        rq = (which == 0) ? rxq0 : rxq1;
        ix = (which == 0) ? i0 : i1;
        check_val({p, ".S"},          32'(s),     32'(e.s));
        check_val({p, ".R"},          32'(r),     32'(e.r));
        check_val({p, ".S_and_R"},    32'(s & r), 32'd0);
        check_val({p, ".busy"},       32'(b),     32'(e.busy));
        check_val({p, ".in_ready"},   32'(rd),    32'(e.rdy));
        check_val({p, ".frame_done"}, 32'(d),     32'(e.done));
        check_val({p, ".q_model"},    32'(q),     32'(e.q));
        check_val({p, ".rx_q"},       32'(rq),    32'(e.q));
        check_val({p, ".bit_idx"},    32'(ix),    32'(e.idx));
    endtask

    // One clock: drive inputs, let the edge happen, check on the falling edge.
    task automatic step(input logic v, input logic [W-1:0] d);
        exp_t e0, e1;
        drv_v = v;
        drv_d = d;
        if (v && model_rdy) begin
            push_frame(0, d);
            push_frame(1, d);
            frames++;
        end
        @(posedge clk);
        @(negedge clk);
        e0 = (exp0.size() != 0) ? exp0.pop_front() : idle_exp(0);
        e1 = (exp1.size() != 0) ? exp1.pop_front() : idle_exp(1);
        compare(0, e0);
        compare(1, e1);
        last0     = e0;
        model_rdy = (exp0.size() == 0);
    endtask

    task automatic send(input logic [W-1:0] w);
        int n;
        step(1'b1, w);
        n = 0;
        while (!model_rdy && n < 4 * W) begin
            step(1'b0, W'($urandom));
            n++;
        end
        check_val("send_bound", 32'(model_rdy), 32'd1);
    endtask

    task automatic check_reset_values();
        check_val("rst.d0.S",     32'(s0), 32'd0);
        check_val("rst.d0.R",     32'(r0), 32'd0);
        check_val("rst.d0.q",     32'(qm0), 32'd0);
        check_val("rst.d0.rdy",   32'(if0.in_ready), 32'd1);
        check_val("rst.d0.busy",  32'(b0), 32'd0);
        check_val("rst.d0.done",  32'(d0), 32'd0);
        check_val("rst.d1.S",     32'(s1), 32'd0);
        check_val("rst.d1.R",     32'(r1), 32'd0);
        check_val("rst.d1.q",     32'(qm1), 32'd1);
        check_val("rst.d1.busy",  32'(b1), 32'd0);
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic pulse_reset();
        drv_v = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        exp0.delete();
        exp1.delete();
        model_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int target;
        drv_v     = 1'b0;
        drv_d     = '0;
        model_rdy = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, '0);
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        step(1'b0, '0);

        // Reset while the fifth bit (index 4) is on the wire.
        step(1'b1, 8'hFF);
        n = 0;
        while (!(last0.busy && last0.idx == 4 && !last0.rdy && n > 0) && n < 4 * W) begin
            step(1'b0, '0);
            n++;
        end
        check_val("reach_idx4", 32'(last0.idx), 32'd4);
        pulse_reset();
        step(1'b0, '0);
        send(8'h3C);

        // in_valid held high with data changing every cycle.
        for (int c = 0; c < 5 * (W + 3); c++) step(1'b1, W'($urandom));
        n = 0;
        while (!model_rdy && n < 4 * W) begin
            step(1'b0, '0);
            n++;
        end

        // Randomised traffic until 1000 further frames have been accepted.
        target = frames + 1000;
        n = 0;
        while (frames < target && n < 40000) begin
            step($urandom_range(0, 3) != 0, W'($urandom));
            n++;
        end
        check_val("random_frames_bound", 32'(frames >= target), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sr_excitation_tx
`default_nettype wire
